muldiv_sequencer: RTL

Iterative sequencer for RV32M multiply/divide/remainder operations.
- The single-cycle ALU keeps the base-integer operations; this block takes every M-extension op the execute stage issues.
- It runs a radix-2 shift-add or shift-subtract loop over XLEN cycles and raises BUSY so the pipeline stalls.
- It returns the result, with the destination tag, over a valid/ready handshake.

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_iter_step.sv | 55 +++++
 rtl/muldiv_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared definitions for the RV32M multiply/divide sequencer:
//            funct3 op codes, FSM state encoding, operand sign helper.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // Most negative 32-bit value: the dividend of the one signed-divide overflow case
  localparam logic [31:0] MOST_NEG = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Returns {rs1_is_signed, rs2_is_signed} for an op
  function automatic logic [1:0] op_signedness(input logic [2:0] op);
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: return 2'b11;
      OP_MULHSU:                       return 2'b10;
      default:                         return 2'b00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter_step
// Purpose  : One radix-2 iteration, purely combinational.
//            mode_i=0: shift-add multiply step on {hi, lo} where lo holds the
//                      remaining multiplier bits (LSB first).
//            mode_i=1: restoring shift-subtract divide step on {rem, quo}
//                      where quo holds the remaining dividend bits (MSB first).
//            In divide mode bit 0 of acc_o is left clear; the new quotient bit
//            is returned on qbit_o for the caller to merge.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  input  logic              mode_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              qbit_o
);

  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_cand;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  assign w_hi = acc_i[2*XLEN-1:XLEN];
  assign w_lo = acc_i[XLEN-1:0];

  // Multiply: conditional add of the multiplicand, carry kept for the shift
  assign w_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, operand_i} : {(XLEN+1){1'b0}});

  // Divide: bring the next dividend bit into the partial remainder
  assign w_cand = {w_hi, w_lo[XLEN-1]};
  assign w_ge   = (w_cand >= {1'b0, operand_i});
  // Only taken when w_cand >= divisor, so the difference always fits XLEN bits
  assign w_diff = w_cand[XLEN-1:0] - operand_i;

  // Select the iteration flavour
  always_comb begin
    acc_o  = '0;
    qbit_o = 1'b0;
    if (mode_i) begin
      qbit_o = w_ge;
      acc_o  = {(w_ge ? w_diff : w_cand[XLEN-1:0]), w_lo[XLEN-2:0], 1'b0};
    end else begin
      acc_o  = {w_sum, w_lo[XLEN-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative RV32M multiply / divide / remainder unit. Operands are
//            reduced to magnitudes, XLEN radix-2 iterations run on an
//            accumulator, then a two's-complement sign fix produces the result,
//            returned with its destination tag over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  data1_i,
  input  logic [XLEN-1:0]  data2_i,
  input  logic [TAG_W-1:0] tag_in_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_out_o
);

  localparam int              CNT_W       = $clog2(XLEN);
  localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] C_MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] C_ALL_ONES  = {XLEN{1'b1}};

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic                special_q, special_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [TAG_W-1:0]    tag_q, tag_d;

  logic [1:0]          w_sgn;
  logic                w_s1;
  logic                w_s2;
  logic                w_is_div;
  logic                w_is_rem;
  logic [XLEN-1:0]     w_mag_a;
  logic [XLEN-1:0]     w_mag_b;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_special_res;
  logic [2*XLEN-1:0]   w_step_acc;
  logic                w_step_qbit;
  logic [2*XLEN-1:0]   w_step_next;
  logic [2*XLEN-1:0]   w_prod_fixed;
  logic [XLEN-1:0]     w_quo_fixed;
  logic [XLEN-1:0]     w_rem_fixed;
  logic [XLEN-1:0]     w_fix_result;

  // ---------------- PREP: signs, magnitudes and special cases ----------------
  assign w_sgn      = op_signedness(op_q);
  assign w_s1       = w_sgn[1] & a_q[XLEN-1];
  assign w_s2       = w_sgn[0] & b_q[XLEN-1];
  assign w_is_div   = op_q[2];
  assign w_is_rem   = op_q[2] & op_q[1];
  assign w_mag_a    = w_s1 ? (~a_q + 1'b1) : a_q;
  assign w_mag_b    = w_s2 ? (~b_q + 1'b1) : b_q;
  assign w_div_zero = w_is_div & (b_q == '0);
  assign w_div_ovf  = ((op_q == OP_DIV) | (op_q == OP_REM)) &
                      (a_q == C_MOST_NEG) & (b_q == C_ALL_ONES);
  assign w_special  = w_div_zero | w_div_ovf;

  // Fixed results that bypass the iteration loop
  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = w_is_rem ? a_q : C_ALL_ONES;
    end else if (w_div_ovf) begin
      w_special_res = w_is_rem ? '0 : C_MOST_NEG;
    end
  end

  // ---------------- CALC: single shared iteration datapath ----------------
  muldiv_iter_step #(
    .XLEN (XLEN)
  ) u_iter_step (
    .acc_i     (acc_q),
    .operand_i (b_q),
    .mode_i    (w_is_div),
    .acc_o     (w_step_acc),
    .qbit_o    (w_step_qbit)
  );

  assign w_step_next = {w_step_acc[2*XLEN-1:1], w_step_acc[0] | w_step_qbit};

  // ---------------- FIX: sign correction and word select ----------------
  assign w_prod_fixed = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign w_quo_fixed  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
  assign w_rem_fixed  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

  // Pick the architectural result word for the op (special results pass through)
  always_comb begin
    w_fix_result = '0;
    if (special_q) begin
      w_fix_result = acc_q[XLEN-1:0];
    end else begin
      unique case (op_q)
        OP_MUL:                       w_fix_result = w_prod_fixed[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod_fixed[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              w_fix_result = w_quo_fixed;
        OP_REM, OP_REMU:              w_fix_result = w_rem_fixed;
        default:                      w_fix_result = '0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition. Special results still
  // pass through FIX so they appear two edges after accept.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start_valid_i) state_d = PREP;
        PREP:    state_d = w_special ? FIX : CALC;
        CALC:    if (cnt_q == C_LAST_ITER) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    if (result_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next-state; nothing is captured or committed while flushing
  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    special_d = special_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    tag_d     = tag_q;
    if (!flush_i) begin
      unique case (state_q)
        IDLE: begin
          if (start_valid_i) begin
            op_d  = op_i;
            a_d   = data1_i;
            b_d   = data2_i;
            tag_d = tag_in_i;
          end
        end
        PREP: begin
          cnt_d     = '0;
          b_d       = w_mag_b;
          neg_d     = w_is_rem ? w_s1 : (w_s1 ^ w_s2);
          special_d = w_special;
          acc_d     = {{XLEN{1'b0}}, (w_special ? w_special_res : w_mag_a)};
        end
        CALC: begin
          acc_d = w_step_next;
          cnt_d = cnt_q + CNT_W'(1);
        end
        FIX: begin
          result_d = w_fix_result;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      tag_q     <= '0;
    end else begin
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      tag_q     <= tag_d;
    end
  end

  assign start_ready_o  = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign result_valid_o = (state_q == DONE);
  assign result_o       = result_q;
  assign tag_out_o      = tag_q;

endmodule
`default_nettype wire
